sar_adc_conv_scheduler: RTL

- Shares one SAR ADC core (N_BITS result, hold input, eoc output) between N_CH requesting channels.
- Arbitrates pending requests round-robin and drives the analog mux select.
- Sequences settle, hold and convert, captures the result on eoc, and returns it with the channel tag.
- Sits between the channel front-ends and the ADC instance; includes a timeout watchdog for a stuck eoc.

---
 rtl/sar_ctrl_pkg.sv | 22 ++
 rtl/sar_rr_arbiter.sv | 40 ++++
 rtl/sar_adc_conv_scheduler.sv | 134 +++++++++++++
 3 files changed

// File: rtl/sar_ctrl_pkg.sv
// Shared definitions for the SAR ADC conversion scheduler.
//   - sar_state_e   : scheduler states (IDLE, SETTLE, CONVERT, DONE)
//   - *_DEFAULT     : default channel count and result width
//   - ch_idx_w()    : width of a channel index for a given channel count
package sar_ctrl_pkg;

  localparam int N_BITS_DEFAULT = 10;
  localparam int N_CH_DEFAULT   = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CONVERT = 2'd2,
    DONE    = 2'd3
  } sar_state_e;

  // Never returns 0, so a channel index always has at least one bit.
  function automatic int ch_idx_w(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/sar_rr_arbiter.sv
// Round-robin request picker (purely combinational).
//   req     : level request per channel
//   rr_ptr  : channel with highest priority this round
//   any_req : at least one request pending
//   idx     : first requesting channel scanning upward from rr_ptr with wrap
module sar_rr_arbiter
  import sar_ctrl_pkg::*;
#(
  parameter  int N_CH = N_CH_DEFAULT,
  localparam int CH_W = ch_idx_w(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] rr_ptr,
  output logic            any_req,
  output logic [CH_W-1:0] idx
);

  logic [CH_W:0] pos;
  logic          found;

  // NOTE: every variable gets a value before the loop so no path leaves
  // it unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int i = 0; i < N_CH; i++) begin
      // rr_ptr + i is below 2*N_CH, so one conditional subtract wraps it.
      pos = {1'b0, rr_ptr} + (CH_W+1)'(i);
      if (pos >= (CH_W+1)'(N_CH)) pos = pos - (CH_W+1)'(N_CH);
      if (!found && req[pos[CH_W-1:0]]) begin
        idx   = pos[CH_W-1:0];
        found = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/sar_adc_conv_scheduler.sv
// Shares one SAR ADC core between N_CH requesting channels.
// Arbitrates round-robin, drives the analog mux select, waits SETTLE_CYCLES,
// holds the sample while the ADC converts, captures the result on eoc (or
// returns 0 with timeout_err after TIMEOUT_CYCLES) and tags it with the channel.
//   clk, reset          : system clock, synchronous active-high reset
//   req                 : level request per channel
//   grant               : one-hot pulse for the served channel (DONE cycle)
//   ch_sel              : analog mux select
//   adc_hold            : sample hold to the ADC, high for all of CONVERT
//   adc_eoc, adc_result : ADC end-of-conversion and result
//   result_data/ch      : last result and its channel, held until next DONE
//   result_valid        : one-cycle pulse when result_data/result_ch update
//   timeout_err         : pulse alongside result_valid for a timed-out conversion
//   busy                : high whenever the scheduler is not IDLE
module sar_adc_conv_scheduler
  import sar_ctrl_pkg::*;
#(
  parameter  int N_CH           = N_CH_DEFAULT,
  parameter  int N_BITS         = N_BITS_DEFAULT,
  parameter  int SETTLE_CYCLES  = 2,
  parameter  int TIMEOUT_CYCLES = 64,
  localparam int CH_W           = ch_idx_w(N_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_CH-1:0]   req,
  output logic [N_CH-1:0]   grant,
  output logic [CH_W-1:0]   ch_sel,
  output logic              adc_hold,
  input  logic              adc_eoc,
  input  logic [N_BITS-1:0] adc_result,
  output logic [N_BITS-1:0] result_data,
  output logic [CH_W-1:0]   result_ch,
  output logic              result_valid,
  output logic              timeout_err,
  output logic              busy
);

  // One counter serves both SETTLE and CONVERT; it is cleared on every entry.
  localparam int CNT_MAX = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [N_CH-1:0]  ONE_HOT0    = N_CH'(1);

  sar_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [CH_W-1:0]  rr_ptr;
  logic             any_req;
  logic [CH_W-1:0]  arb_idx;

  sar_rr_arbiter #(.N_CH(N_CH)) u_arb (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .any_req (any_req),
    .idx     (arb_idx)
  );

  // NOTE: state and outputs are registers, so they take non-blocking
  // assignments; every read in this block sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      rr_ptr       <= '0;
      grant        <= '0;
      ch_sel       <= '0;
      adc_hold     <= 1'b0;
      result_data  <= '0;
      result_ch    <= '0;
      result_valid <= 1'b0;
      timeout_err  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      grant        <= '0;
      result_valid <= 1'b0;
      timeout_err  <= 1'b0;

      case (state)
        IDLE: begin
          if (any_req) begin
            ch_sel <= arb_idx;
            cnt    <= '0;
            busy   <= 1'b1;
            if (SETTLE_CYCLES == 0) begin
              state    <= CONVERT;
              adc_hold <= 1'b1;
            end else begin
              state <= SETTLE;
            end
          end
        end

        SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            state    <= CONVERT;
            cnt      <= '0;
            adc_hold <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        CONVERT: begin
          // eoc is tested first, so eoc on the final timeout cycle is a
          // normal completion.
          if (adc_eoc || cnt == TO_LAST) begin
            state        <= DONE;
            cnt          <= '0;
            adc_hold     <= 1'b0;
            result_valid <= 1'b1;
            result_ch    <= ch_sel;
            grant        <= ONE_HOT0 << ch_sel;
            timeout_err  <= ~adc_eoc;
            result_data  <= adc_eoc ? adc_result : '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        DONE: begin
          // Going back through IDLE keeps hold low for at least one cycle
          // between conversions.
          state  <= IDLE;
          busy   <= 1'b0;
          rr_ptr <= (ch_sel == CH_W'(N_CH - 1)) ? '0 : ch_sel + CH_W'(1);
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
